// File: rtl/vdcm_out_pkg.sv
// Shared types and constants for the slice output scheduler.
// Beat geometry, FSM encoding, marker bundle and tail-mask helper.
package vdcm_out_pkg;

  localparam int PIX_BITS     = 14;
  localparam int PIX_PER_BEAT = 4;
  localparam int NUM_CP       = 3;
  localparam int BEAT_W       = PIX_PER_BEAT * NUM_CP * PIX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } mark_t;

  function automatic logic [3:0] tail_mask(input logic [1:0] rem);
    logic [3:0] m;
    if (rem == 2'd0) m = 4'b1111;
    else m = (4'b0001 << rem) - 4'd1;
    return m;
  endfunction

endpackage

// File: rtl/sched_counters.sv
// Beat/slice/line counters with picture geometry latched on start.
// Ports: clr/latch/adv controls, geometry in; slice index, markers, mask, frame_last out.
module sched_counters
  import vdcm_out_pkg::*;
#(
  parameter int SW_W  = 13,
  parameter int SPL_W = 3,
  parameter int FH_W  = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             latch,
  input  logic             adv,
  input  logic [SW_W-1:0]  slice_width,
  input  logic [SPL_W-1:0] slices_per_line,
  input  logic [FH_W-1:0]  frame_height,
  output logic [SPL_W-1:0] s_idx,
  output mark_t            marks,
  output logic [3:0]       mask,
  output logic             frame_last
);

  localparam int BW = SW_W - 1;

  logic [BW-1:0]    b_q, b_d;
  logic [SPL_W-1:0] s_q, s_d;
  logic [FH_W-1:0]  y_q, y_d;
  logic [BW-1:0]    bpl_m1_q, bpl_m1_d;
  logic [SPL_W-1:0] spl_m1_q, spl_m1_d;
  logic [FH_W-1:0]  fh_m1_q, fh_m1_d;
  logic [3:0]       lmask_q, lmask_d;

  logic [BW-1:0] bpl;
  logic          b_last;
  logic          s_last;
  logic          y_last;

  always_comb begin
    // ceil(width/4) without a wide adder
    bpl = {1'b0, slice_width[SW_W-1:2]}
        + BW'(slice_width[1:0] != 2'b00);

    b_last = (b_q == bpl_m1_q);
    s_last = (s_q == spl_m1_q);
    y_last = (y_q == fh_m1_q);

    marks.sol = (s_q == '0) && (b_q == '0);
    marks.eol = s_last && b_last;
    marks.sof = marks.sol && (y_q == '0);
    marks.eof = marks.eol && y_last;
    mask = b_last ? lmask_q : 4'b1111;
    frame_last = b_last && s_last && y_last;
    s_idx = s_q;

    bpl_m1_d = bpl_m1_q;
    spl_m1_d = spl_m1_q;
    fh_m1_d  = fh_m1_q;
    lmask_d  = lmask_q;
    if (latch) begin
      bpl_m1_d = bpl - BW'(1);
      spl_m1_d = slices_per_line - SPL_W'(1);
      fh_m1_d  = frame_height - FH_W'(1);
      lmask_d  = tail_mask(slice_width[1:0]);
    end

    b_d = b_q;
    s_d = s_q;
    y_d = y_q;
    if (clr) begin
      b_d = '0;
      s_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (b_last) begin
        b_d = '0;
        if (s_last) begin
          s_d = '0;
          y_d = y_last ? '0 : y_q + FH_W'(1);
        end else begin
          s_d = s_q + SPL_W'(1);
        end
      end else begin
        b_d = b_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q      <= '0;
      s_q      <= '0;
      y_q      <= '0;
      bpl_m1_q <= '0;
      spl_m1_q <= '0;
      fh_m1_q  <= '0;
      lmask_q  <= 4'b1111;
    end else begin
      b_q      <= b_d;
      s_q      <= s_d;
      y_q      <= y_d;
      bpl_m1_q <= bpl_m1_d;
      spl_m1_q <= spl_m1_d;
      fh_m1_q  <= fh_m1_d;
      lmask_q  <= lmask_d;
    end
  end

endmodule

// File: rtl/slice_output_scheduler.sv
// Merges per-slice 4-pixel streams into one raster stream with framing.
// Ports: per-slice in_valid/in_data/in_ready, single out stream, start/flush/busy.
module slice_output_scheduler
  import vdcm_out_pkg::*;
#(
  parameter int NUM_SLICES       = 4,
  parameter int MAX_SLICE_WIDTH  = 2560,
  parameter int MAX_FRAME_HEIGHT = 4096,
  localparam int SW_W  = $clog2(MAX_SLICE_WIDTH) + 1,
  localparam int SPL_W = $clog2(NUM_SLICES) + 1,
  localparam int FH_W  = $clog2(MAX_FRAME_HEIGHT) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         start,
  input  logic [SW_W-1:0]              slice_width,
  input  logic [SPL_W-1:0]             slices_per_line,
  input  logic [FH_W-1:0]              frame_height,
  input  logic [NUM_SLICES-1:0]        in_valid,
  input  logic [NUM_SLICES*BEAT_W-1:0] in_data,
  output logic [NUM_SLICES-1:0]        in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BEAT_W-1:0]            out_data,
  output logic [3:0]                   out_mask,
  output logic                         out_sol,
  output logic                         out_eol,
  output logic                         out_sof,
  output logic                         out_eof,
  output logic                         busy
);

  sched_state_e state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [BEAT_W-1:0] out_data_q, out_data_d;
  logic [3:0]        out_mask_q, out_mask_d;
  mark_t             mark_q, mark_d;

  logic [SPL_W-1:0]      s_idx;
  mark_t                 marks;
  logic [3:0]            cnt_mask;
  logic                  frame_last;
  logic [NUM_SLICES-1:0] sel_oh;
  logic [BEAT_W-1:0]     dsel;
  logic                  vsel;
  logic                  can_load;
  logic                  load;
  logic                  is_idle;

  sched_counters #(
    .SW_W  (SW_W),
    .SPL_W (SPL_W),
    .FH_W  (FH_W)
  ) u_cnt (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr             (flush | is_idle),
    .latch           (is_idle & start & ~flush),
    .adv             (load),
    .slice_width     (slice_width),
    .slices_per_line (slices_per_line),
    .frame_height    (frame_height),
    .s_idx           (s_idx),
    .marks           (marks),
    .mask            (cnt_mask),
    .frame_last      (frame_last)
  );

  always_comb begin
    is_idle = (state_q == ST_IDLE);
    sel_oh  = '0;
    dsel    = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      sel_oh[i] = (s_idx == SPL_W'(i));
      dsel = dsel | (in_data[i*BEAT_W +: BEAT_W] & {BEAT_W{sel_oh[i]}});
    end
    vsel = |(in_valid & sel_oh);

    // ready depends on state and output space only, never on in_valid
    can_load = (state_q == ST_XFER) && (!out_valid_q || out_ready);
    load     = can_load && vsel && !flush;
    in_ready = can_load ? sel_oh : '0;

    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    mark_d      = mark_q;

    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_XFER;
      ST_XFER: if (load && frame_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = dsel;
      out_mask_d  = cnt_mask;
      mark_d      = marks;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_mask_d  = '0;
      mark_d      = '0;
    end

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_mask_d  = '0;
      mark_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      mark_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      mark_q      <= mark_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_sol   = mark_q.sol;
  assign out_eol   = mark_q.eol;
  assign out_sof   = mark_q.sof;
  assign out_eof   = mark_q.eof;
  assign busy      = !is_idle;

endmodule

// File: tb/tb_slice_output_scheduler.sv
// Directed bench for slice_output_scheduler.
// Expected beats come from hand tables and a small raster model.
module tb_slice_output_scheduler;

  localparam int NS    = 4;
  localparam int BW    = 168;
  localparam int SW_W  = 13;
  localparam int SPL_W = 3;
  localparam int FH_W  = 13;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              start;
  logic [SW_W-1:0]   slice_width;
  logic [SPL_W-1:0]  slices_per_line;
  logic [FH_W-1:0]   frame_height;
  logic [NS-1:0]     in_valid;
  logic [NS*BW-1:0]  in_data;
  logic [NS-1:0]     in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic [3:0]        out_mask;
  logic              out_sol;
  logic              out_eol;
  logic              out_sof;
  logic              out_eof;
  logic              busy;

  slice_output_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .start           (start),
    .slice_width     (slice_width),
    .slices_per_line (slices_per_line),
    .frame_height    (frame_height),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_mask        (out_mask),
    .out_sol         (out_sol),
    .out_eol         (out_eol),
    .out_sof         (out_sof),
    .out_eof         (out_eof),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tid;
    int         sl;
    int         idx;
    logic [3:0] mask;
    logic [3:0] mk;
  } exp_t;

  exp_t exp_q[$];
  exp_t tbl[11];

  int checks = 0;
  int failures = 0;

  int       cnt[NS];
  logic [NS-1:0] take_n;
  logic     clr_cnt;
  logic     stall_prev;
  logic [BW-1:0] stall_data;
  logic [3:0] stall_mk;

  function automatic logic [BW-1:0] make_beat(int s, int idx);
    logic [BW-1:0] r;
    logic [15:0]   tag;
    logic [31:0]   sv;
    logic [31:0]   iv;
    sv  = s;
    iv  = idx;
    tag = {4'hA, sv[3:0], iv[7:0]};
    r   = '0;
    for (int k = 0; k < 10; k++) r[k*16 +: 16] = tag;
    r[167:160] = tag[7:0];
    return r;
  endfunction

  always_comb begin
    in_data = '0;
    for (int i = 0; i < NS; i++)
      in_data[i*BW +: BW] = make_beat(i, cnt[i]);
  end

  always @(negedge clk) take_n <= in_valid & in_ready;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (clr_cnt) cnt[i] <= 0;
      else if (take_n[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  // output monitor: scoreboard pop on handshake, hold check while stalled
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] mk;
    mk = {out_sol, out_eol, out_sof, out_eof};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_data !== stall_data || mk !== stall_mk) begin
          failures++;
          $display("FAIL stall_hold v=%b mk=%b want mk=%b", out_valid, mk, stall_mk);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_extra got mk=%b data[15:0]=%h", mk, out_data[15:0]);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== make_beat(e.sl, e.idx) || out_mask !== e.mask || mk !== e.mk) begin
            failures++;
            $display("FAIL beat t%0d s%0d i%0d got tag=%h mask=%b mk=%b want tag=%h mask=%b mk=%b",
                     e.tid, e.sl, e.idx, out_data[15:0], out_mask, mk,
                     make_beat(e.sl, e.idx)[15:0], e.mask, e.mk);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_mk   = mk;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic gen(int spl, int w, int h);
    int bpl;
    logic [3:0] lm;
    exp_t e;
    bpl = (w + 3) / 4;
    lm  = (w % 4 == 0) ? 4'b1111 : 4'((1 << (w % 4)) - 1);
    for (int y = 0; y < h; y++)
      for (int s = 0; s < spl; s++)
        for (int b = 0; b < bpl; b++) begin
          logic sol, eol;
          sol = (s == 0) && (b == 0);
          eol = (s == spl - 1) && (b == bpl - 1);
          e.tid  = 9;
          e.sl   = s;
          e.idx  = y * bpl + b;
          e.mask = (b == bpl - 1) ? lm : 4'b1111;
          e.mk   = {sol, eol, sol && y == 0, eol && y == h - 1};
          exp_q.push_back(e);
        end
  endtask

  task automatic do_start(int spl, int w, int h);
    @(posedge clk); #1;
    slice_width     = SW_W'(w);
    slices_per_line = SPL_W'(spl);
    frame_height    = FH_W'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // geometry changes after start must not matter
    slice_width     = 13'd5;
    slices_per_line = 3'd1;
    frame_height    = 13'd7;
  endtask

  task automatic clear_src();
    @(posedge clk); #1 clr_cnt = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
  endtask

  task automatic drain(string name, int max, bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    n = 0;
    while ((busy || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 4'b1111, 4'b1010};
    tbl[1]  = '{1, 0, 1, 4'b1111, 4'b0000};
    tbl[2]  = '{1, 1, 0, 4'b1111, 4'b0000};
    tbl[3]  = '{1, 1, 1, 4'b1111, 4'b0100};
    tbl[4]  = '{1, 0, 2, 4'b1111, 4'b1000};
    tbl[5]  = '{1, 0, 3, 4'b1111, 4'b0000};
    tbl[6]  = '{1, 1, 2, 4'b1111, 4'b0000};
    tbl[7]  = '{1, 1, 3, 4'b1111, 4'b0101};
    tbl[8]  = '{2, 0, 0, 4'b1111, 4'b1010};
    tbl[9]  = '{2, 0, 1, 4'b1111, 4'b0000};
    tbl[10] = '{2, 0, 2, 4'b0011, 4'b0101};

    rst_n = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    slice_width = '0;
    slices_per_line = '0;
    frame_height = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    stall_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {out_valid, out_mask, out_sol, out_eol, out_sof, out_eof},
        32'd0);
    chk("rst_rdy_busy", {in_ready, busy}, 32'd0);
    rst_n = 1'b1;
    clr_cnt = 1'b0;

    // tables: 2 slices x 8 px x 2 lines, then 1 slice x 10 px x 1 line
    for (int t = 1; t <= 2; t++) begin
      clear_src();
      for (int i = 0; i < 11; i++)
        if (tbl[i].tid == t) exp_q.push_back(tbl[i]);
      if (t == 1) do_start(2, 8, 2);
      else do_start(1, 10, 1);
      if (t == 1) begin
        // re-start while busy is ignored
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      drain($sformatf("table%0d", t), 200, 1'b0);
    end

    // slice 1 withholds data at its turn
    begin
      int n;
      clear_src();
      in_valid = 4'b0001;
      gen(2, 8, 1);
      do_start(2, 8, 1);
      n = 0;
      while (cnt[0] < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wait_s0_taken", 32'(cnt[0]), 32'd2);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("wait_rdy0", {31'd0, in_ready[0]}, 32'd0);
        chk("wait_cnt0", 32'(cnt[0]), 32'd2);
      end
      @(posedge clk); #1 in_valid = '1;
      drain("stall_src", 200, 1'b0);
    end

    // random backpressure on 4 slices, 16 px, 3 lines
    clear_src();
    gen(4, 16, 3);
    chk("rand_expect_len", 32'(exp_q.size()), 32'd48);
    do_start(4, 16, 3);
    drain("rand_rdy", 2000, 1'b1);

    // flush at y=1 s=1 b=0, then restart
    begin
      int n;
      clear_src();
      gen(2, 8, 2);
      do_start(2, 8, 2);
      n = 0;
      while (!(cnt[0] == 4 && cnt[1] == 2) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("flush_pos", 32'(cnt[0] * 16 + cnt[1]), 32'h42);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_state", {in_ready, out_valid, busy}, 32'd0);
      exp_q.delete();
      clear_src();
      gen(2, 8, 2);
      do_start(2, 8, 2);
      drain("after_flush", 200, 1'b0);
    end

    // asynchronous reset mid-transfer
    clear_src();
    gen(4, 16, 3);
    do_start(4, 16, 3);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out",
        {out_valid, out_mask, out_sol, out_eol, out_sof, out_eof}, 32'd0);
    chk("async_rst_rdy", {in_ready, busy}, 32'd0);
    exp_q.delete();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    rst_n = 1'b1;
    gen(2, 8, 2);
    slice_width     = 13'd8;
    slices_per_line = 3'd2;
    frame_height    = 13'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    drain("after_rst", 200, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
